// File: rtl/dot_acc_pipe.sv
// Streaming dot-product engine: two-stage multiply pipeline feeding a
// wrapping accumulator, with a held result released by a ready handshake.
module dot_acc_pipe #(
  parameter int A_WIDTH   = 16,
  parameter int B_WIDTH   = 16,
  parameter int ACC_WIDTH = 40
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  input  logic                 i_last,
  input  logic [A_WIDTH-1:0]   i_a,
  input  logic [B_WIDTH-1:0]   i_b,
  input  logic                 i_tc,
  output logic                 o_ready,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [ACC_WIDTH-1:0] o_sum,
  output logic [7:0]           o_len
);

  localparam int P_WIDTH = A_WIDTH + B_WIDTH;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  logic [1:0]           state_q, state_d;
  logic                 accept;

  logic                 s1Valid_q, s1Last_q, s1First_q, s1Tc_q;
  logic [A_WIDTH-1:0]   s1A_q;
  logic [B_WIDTH-1:0]   s1B_q;

  logic                 s2Valid_q, s2Last_q, s2First_q, s2Tc_q;
  logic [P_WIDTH-1:0]   s2Prod_q;

  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [ACC_WIDTH-1:0] sum_q, sum_d;
  logic [7:0]           len_q, len_d;

  logic [P_WIDTH-1:0]   aExt, bExt, prodFull;
  logic [ACC_WIDTH-1:0] prodExt, accSum;

  assign o_ready = (state_q == IDLE) || (state_q == ACCUM);
  assign o_valid = (state_q == HOLD);
  assign o_sum   = sum_q;
  assign o_len   = len_q;
  assign accept  = i_valid && o_ready;

  // Extending both operands to the full product width first makes the
  // truncated product correct for both signed and unsigned operands.
  always_comb begin
    aExt     = s1Tc_q ? P_WIDTH'($signed(s1A_q)) : P_WIDTH'(s1A_q);
    bExt     = s1Tc_q ? P_WIDTH'($signed(s1B_q)) : P_WIDTH'(s1B_q);
    prodFull = aExt * bExt;
    prodExt  = s2Tc_q ? ACC_WIDTH'($signed(s2Prod_q)) : ACC_WIDTH'(s2Prod_q);
    accSum   = (s2First_q ? '0 : acc_q) + prodExt;
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    len_d   = len_q;

    if (s2Valid_q) acc_d = accSum;
    if (accept) cnt_d = (state_q == IDLE) ? 8'd1 : cnt_q + 8'd1;

    case (state_q)
      IDLE, ACCUM: begin
        if (accept) state_d = i_last ? DRAIN : ACCUM;
      end
      DRAIN: begin
        if (s2Valid_q && s2Last_q) begin
          state_d = HOLD;
          sum_d   = accSum;
          len_d   = cnt_q;
        end
      end
      HOLD: begin
        if (i_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset clears control and valid bits; pipeline data is don't-care then.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      s1Valid_q <= 1'b0;
      s1Last_q  <= 1'b0;
      s1First_q <= 1'b0;
      s1Tc_q    <= 1'b0;
      s1A_q     <= '0;
      s1B_q     <= '0;
      s2Valid_q <= 1'b0;
      s2Last_q  <= 1'b0;
      s2First_q <= 1'b0;
      s2Tc_q    <= 1'b0;
      s2Prod_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      sum_q     <= '0;
      len_q     <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      sum_q     <= sum_d;
      len_q     <= len_d;

      s1Valid_q <= accept;
      if (accept) begin
        s1Last_q  <= i_last;
        s1First_q <= (state_q == IDLE);
        s1Tc_q    <= i_tc;
        s1A_q     <= i_a;
        s1B_q     <= i_b;
      end

      s2Valid_q <= s1Valid_q;
      if (s1Valid_q) begin
        s2Last_q  <= s1Last_q;
        s2First_q <= s1First_q;
        s2Tc_q    <= s1Tc_q;
        s2Prod_q  <= prodFull;
      end
    end
  end

endmodule

// File: tb/tb_dot_acc_pipe.sv
// Directed bench for dot_acc_pipe: hand-computed vectors covering signed,
// unsigned, bubbles, result hold, mid-vector reset and count wrap.
module tb_dot_acc_pipe;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_valid = 1'b0;
  logic        i_last = 1'b0;
  logic [15:0] i_a = '0;
  logic [15:0] i_b = '0;
  logic        i_tc = 1'b0;
  logic        o_ready;
  logic        o_valid;
  logic        i_ready = 1'b0;
  logic [39:0] o_sum;
  logic [7:0]  o_len;

  int checks = 0;
  int errors = 0;

  dot_acc_pipe #(.A_WIDTH(16), .B_WIDTH(16), .ACC_WIDTH(40)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_last(i_last),
    .i_a(i_a), .i_b(i_b), .i_tc(i_tc), .o_ready(o_ready), .o_valid(o_valid),
    .i_ready(i_ready), .o_sum(o_sum), .o_len(o_len)
  );

  always #5 i_clk = ~i_clk;

  // Drive one cycle of inputs, let the rising edge take them, then settle.
  task automatic applyStimulus(input logic valid, input logic last,
                               input logic [15:0] a, input logic [15:0] b,
                               input logic tc, input logic ready);
    i_valid = valid;
    i_last  = last;
    i_a     = a;
    i_b     = b;
    i_tc    = tc;
    i_ready = ready;
    @(posedge i_clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    // Reset state
    applyStimulus(1'b1, 1'b0, 16'd5, 16'd5, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
    i_rst = 1'b0;
    checkOutput("reset o_valid", 64'(o_valid), 64'd0);
    checkOutput("reset o_sum", 64'(o_sum), 64'd0);
    checkOutput("reset o_len", 64'(o_len), 64'd0);
    checkOutput("reset o_ready", 64'(o_ready), 64'd1);

    // Signed {3,-2,7} . {4,5,-1} = -5
    $display("[TB] signed vector");
    applyStimulus(1'b1, 1'b0, 16'd3, 16'd4, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 16'hFFFE, 16'd5, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 16'd7, 16'hFFFF, 1'b1, 1'b0);
    checkOutput("signed E o_ready", 64'(o_ready), 64'd0);
    checkOutput("signed E o_valid", 64'(o_valid), 64'd0);
    applyStimulus(1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
    checkOutput("signed E+1 o_valid", 64'(o_valid), 64'd0);
    applyStimulus(1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
    checkOutput("signed E+2 o_valid", 64'(o_valid), 64'd1);
    checkOutput("signed o_sum", 64'(o_sum), 64'h00FF_FFFF_FFFB);
    checkOutput("signed o_len", 64'(o_len), 64'd3);
    applyStimulus(1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b1);
    checkOutput("signed release o_valid", 64'(o_valid), 64'd0);
    checkOutput("signed release o_ready", 64'(o_ready), 64'd1);

    // Unsigned single element, i_ready held high while draining
    $display("[TB] unsigned single element");
    applyStimulus(1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b1);
    checkOutput("unsigned o_valid", 64'(o_valid), 64'd1);
    checkOutput("unsigned o_sum", 64'(o_sum), 64'h00FF_FE00_01);
    checkOutput("unsigned o_len", 64'(o_len), 64'd1);
    applyStimulus(1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b1);
    checkOutput("unsigned release o_valid", 64'(o_valid), 64'd0);

    // Bubbles mid-vector: 1*1 + 2*2 + 3*3 = 14
    $display("[TB] vector with bubbles");
    applyStimulus(1'b1, 1'b0, 16'd1, 16'd1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 16'd7, 16'd7, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 16'd7, 16'd7, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 16'd2, 16'd2, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 16'd3, 16'd3, 1'b0, 1'b0);
    checkOutput("bubble E o_ready", 64'(o_ready), 64'd0);
    applyStimulus(1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
    checkOutput("bubble E+1 o_ready", 64'(o_ready), 64'd0);
    applyStimulus(1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
    checkOutput("bubble o_valid", 64'(o_valid), 64'd1);
    checkOutput("bubble o_sum", 64'(o_sum), 64'd14);
    checkOutput("bubble o_len", 64'(o_len), 64'd3);

    // Hold for five cycles with ignored input pulses
    $display("[TB] result hold");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, i[0], 16'd9, 16'd9, 1'b0, 1'b0);
      checkOutput("hold o_valid", 64'(o_valid), 64'd1);
      checkOutput("hold o_sum", 64'(o_sum), 64'd14);
      checkOutput("hold o_ready", 64'(o_ready), 64'd0);
    end
    applyStimulus(1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b1);
    checkOutput("hold release o_valid", 64'(o_valid), 64'd0);

    // Reset one cycle after the second element discards the vector
    $display("[TB] mid-vector reset");
    applyStimulus(1'b1, 1'b0, 16'd1, 16'd1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 16'd1, 16'd1, 1'b0, 1'b0);
    i_rst = 1'b1;
    applyStimulus(1'b1, 1'b1, 16'd1, 16'd1, 1'b0, 1'b1);
    i_rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checkOutput("post-reset o_valid", 64'(o_valid), 64'd0);
      checkOutput("post-reset o_ready", 64'(o_ready), 64'd1);
      applyStimulus(1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
    end
    checkOutput("post-reset o_sum", 64'(o_sum), 64'd0);
    applyStimulus(1'b1, 1'b1, 16'd2, 16'd3, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
    checkOutput("after-reset o_valid", 64'(o_valid), 64'd1);
    checkOutput("after-reset o_sum", 64'(o_sum), 64'd6);
    checkOutput("after-reset o_len", 64'(o_len), 64'd1);
    applyStimulus(1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b1);

    // 256 elements: count wraps to 0, sum does not
    $display("[TB] 256-element vector");
    for (int i = 0; i < 256; i++) begin
      applyStimulus(1'b1, (i == 255), 16'd1, 16'd1, 1'b0, 1'b0);
    end
    applyStimulus(1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
    checkOutput("wrap o_valid", 64'(o_valid), 64'd1);
    checkOutput("wrap o_sum", 64'(o_sum), 64'd256);
    checkOutput("wrap o_len", 64'(o_len), 64'd0);
    applyStimulus(1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b1);
    checkOutput("wrap release o_valid", 64'(o_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
